// File: rtl/multicycle_control_v2_pkg.sv
// multicycle_ctrl_pkg: opcodes, FSM states and datapath select encodings for the multicycle control
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB,
        IEXEC, IWB, BEQ, BNE, JUMP, JAL, TRAP
    } stateT;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    localparam logic [2:0] SRCB_B        = 3'b000;
    localparam logic [2:0] SRCB_FOUR     = 3'b001;
    localparam logic [2:0] SRCB_SEXT     = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;
    localparam logic [2:0] SRCB_ZEXT     = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    typedef struct packed {
        logic       pcWriteIfNonZero;
        logic       pcWriteIfZero;
        logic       pcWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic [1:0] memToReg;
        logic       irWrite;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [2:0] aluSrcB;
        logic       aluSrcA;
        logic       regWrite;
        logic [1:0] regDst;
    } ctrlT;

    function automatic logic isLegal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// ctrl_decode_rom: combinational map from FSM state, opcode and memory ready to the datapath strobe bundle
module ctrl_decode_rom
    import multicycle_ctrl_pkg::*;
(
    input  stateT      state,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output ctrlT       ctrl
);

    // every field defaults to 0; each state raises only what it drives
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            DECODE: ctrl.aluSrcB = SRCB_SEXT_SH2;
            MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_SEXT;
                ctrl.aluOp   = ALU_ADD;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RDST_RT;
                ctrl.memToReg = M2R_MDR;
            end
            MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            RTEXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_B;
                ctrl.aluOp   = ALU_FUNCT;
            end
            RTWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RDST_RD;
                ctrl.memToReg = M2R_ALUOUT;
            end
            IEXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_SEXT;
                ctrl.aluOp   = opCode == OP_SLTI ? ALU_SLT : ALU_ADD;
            end
            IWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RDST_RT;
                ctrl.memToReg = M2R_ALUOUT;
            end
            BEQ, BNE: begin
                ctrl.aluSrcA          = 1'b1;
                ctrl.aluSrcB          = SRCB_B;
                ctrl.aluOp            = ALU_SUB;
                ctrl.pcSource         = PCSRC_ALUOUT;
                ctrl.pcWriteIfZero    = state == BEQ;
                ctrl.pcWriteIfNonZero = state == BNE;
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            JAL: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RDST_RA;
                ctrl.memToReg = M2R_PC;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: main control FSM with memory wait states, illegal-opcode trap and retired counter
module multicycle_control_v2
    import multicycle_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic             mem_ready,
    output logic             PCWriteIfNonZero,
    output logic             PCWriteIfZero,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemToReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ALUSrcB,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    stateT state, nextState;
    ctrlT  rom, ctrl;
    logic  ready;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    ctrl_decode_rom uRom (
        .state   (state),
        .opCode  (opCode),
        .memReady(ready),
        .ctrl    (rom)
    );

    // reset low must silence the datapath immediately, even though FETCH itself drives MemRead
    assign ctrl             = reset ? rom : '0;
    assign PCWriteIfNonZero = ctrl.pcWriteIfNonZero;
    assign PCWriteIfZero    = ctrl.pcWriteIfZero;
    assign PCWrite          = ctrl.pcWrite;
    assign IorD             = ctrl.iorD;
    assign MemRead          = ctrl.memRead;
    assign MemWrite         = ctrl.memWrite;
    assign MemToReg         = ctrl.memToReg;
    assign IRWrite          = ctrl.irWrite;
    assign PCSource         = ctrl.pcSource;
    assign ALUOp            = ctrl.aluOp;
    assign ALUSrcB          = ctrl.aluSrcB;
    assign ALUSrcA          = ctrl.aluSrcA;
    assign RegWrite         = ctrl.regWrite;
    assign RegDst           = ctrl.regDst;

    // parked in TRAP, or a single DECODE-cycle pulse when illegal opcodes just fall back to FETCH
    assign illegal_op = reset && (state == TRAP || (!TRAP_ON_ILLEGAL && state == DECODE && !isLegal(opCode)));

    // next-state sequencing; memory states hold until the access completes
    always_comb begin
        nextState = state;
        case (state)
            FETCH:  nextState = ready ? DECODE : FETCH;
            DECODE: begin
                case (opCode)
                    OP_LW, OP_SW:     nextState = MEMADR;
                    OP_RTYPE:         nextState = RTEXEC;
                    OP_ADDI, OP_SLTI: nextState = IEXEC;
                    OP_BEQ:           nextState = BEQ;
                    OP_BNE:           nextState = BNE;
                    OP_J:             nextState = JUMP;
                    OP_JAL:           nextState = JAL;
                    default:          nextState = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEMADR: nextState = opCode == OP_LW ? MEMRD : MEMWR;
            MEMRD:  nextState = ready ? MEMWB : MEMRD;
            MEMWR:  nextState = ready ? FETCH : MEMWR;
            RTEXEC: nextState = RTWB;
            IEXEC:  nextState = IWB;
            TRAP:   nextState = TRAP;
            default: nextState = FETCH;
        endcase
    end

    // state register and retired count; a return to FETCH from past DECODE completes an instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= nextState;
            if (nextState == FETCH && state != FETCH && state != DECODE)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// tb_multicycle_control_v2: directed per-cycle vectors plus trap, reset-abort and no-handshake sequences
module tb_multicycle_control_v2;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [19:0] exp;
        logic        ill;
        logic [31:0] ret;
    } vecT;

    logic clk = 1'b0;
    logic reset = 1'b0, memReady = 1'b0;
    logic [5:0] opCode = 6'h00;
    logic pcnz, pcz, pcw, iord, mr, mw, irw, srca, rw, ill;
    logic [1:0] m2r, pcs, aluop, rd;
    logic [2:0] srcb;
    logic [31:0] ret;

    logic reset1 = 1'b0, rdy1 = 1'b0;
    logic [5:0] op1 = 6'h00;
    logic pcnz1, pcz1, pcw1, iord1, mr1, mw1, irw1, srca1, rw1, ill1;
    logic [1:0] m2r1, pcs1, aluop1, rd1, ret1;
    logic [2:0] srcb1;

    logic [19:0] act, act1;
    logic [19:0] zeroV, fetchRdy, fetchWait, decodeV, memAdr, memRd, memWb, memWr;
    logic [19:0] rtExec, rtWb, iExecAdd, iExecSlt, iWb, beqV, bneV, jumpV, jalV;
    vecT vecs[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign act  = {pcnz, pcz, pcw, iord, mr, mw, m2r, irw, pcs, aluop, srcb, srca, rw, rd};
    assign act1 = {pcnz1, pcz1, pcw1, iord1, mr1, mw1, m2r1, irw1, pcs1, aluop1, srcb1, srca1, rw1, rd1};

    multicycle_control_v2 dut (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(memReady),
        .PCWriteIfNonZero(pcnz), .PCWriteIfZero(pcz), .PCWrite(pcw), .IorD(iord),
        .MemRead(mr), .MemWrite(mw), .MemToReg(m2r), .IRWrite(irw), .PCSource(pcs),
        .ALUOp(aluop), .ALUSrcB(srcb), .ALUSrcA(srca), .RegWrite(rw), .RegDst(rd),
        .illegal_op(ill), .retired(ret)
    );

    multicycle_control_v2 #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset1), .opCode(op1), .mem_ready(rdy1),
        .PCWriteIfNonZero(pcnz1), .PCWriteIfZero(pcz1), .PCWrite(pcw1), .IorD(iord1),
        .MemRead(mr1), .MemWrite(mw1), .MemToReg(m2r1), .IRWrite(irw1), .PCSource(pcs1),
        .ALUOp(aluop1), .ALUSrcB(srcb1), .ALUSrcA(srca1), .RegWrite(rw1), .RegDst(rd1),
        .illegal_op(ill1), .retired(ret1)
    );

    function automatic logic [19:0] mk(input int nz, input int z, input int pw, input int ad, input int rdS,
                                       input int wr, input int m2, input int ir, input int ps, input int ao,
                                       input int sb, input int sa, input int rwS, input int dst);
        return {nz[0], z[0], pw[0], ad[0], rdS[0], wr[0], m2[1:0], ir[0], ps[1:0], ao[1:0], sb[2:0], sa[0], rwS[0], dst[1:0]};
    endfunction

    function automatic vecT v(input int r, input int op, input int rdy, input logic [19:0] e, input int il, input int rt);
        vecT x;
        x.rst = r[0];
        x.op  = op[5:0];
        x.rdy = rdy[0];
        x.exp = e;
        x.ill = il[0];
        x.ret = rt;
        return x;
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    initial begin
        zeroV     = '0;
        fetchRdy  = mk(0,0,1,0,1,0,0,1,0,0,1,0,0,0);
        fetchWait = mk(0,0,0,0,1,0,0,0,0,0,1,0,0,0);
        decodeV   = mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0);
        memAdr    = mk(0,0,0,0,0,0,0,0,0,0,2,1,0,0);
        memRd     = mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0);
        memWb     = mk(0,0,0,0,0,0,1,0,0,0,0,0,1,0);
        memWr     = mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0);
        rtExec    = mk(0,0,0,0,0,0,0,0,0,2,0,1,0,0);
        rtWb      = mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1);
        iExecAdd  = mk(0,0,0,0,0,0,0,0,0,0,2,1,0,0);
        iExecSlt  = mk(0,0,0,0,0,0,0,0,0,3,2,1,0,0);
        iWb       = mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        beqV      = mk(0,1,0,0,0,0,0,0,1,1,0,1,0,0);
        bneV      = mk(1,0,0,0,0,0,0,0,1,1,0,1,0,0);
        jumpV     = mk(0,0,1,0,0,0,0,0,2,0,0,0,0,0);
        jalV      = mk(0,0,1,0,0,0,2,0,2,0,0,0,1,2);

        vecs.push_back(v(0, 'h00, 1, zeroV, 0, 0));
        vecs.push_back(v(1, 'h1A, 0, fetchWait, 0, 0));
        vecs.push_back(v(1, 'h1A, 1, fetchRdy, 0, 0));
        vecs.push_back(v(1, 'h1A, 1, decodeV, 0, 0));
        vecs.push_back(v(1, 'h1A, 1, iExecSlt, 0, 0));
        vecs.push_back(v(1, 'h1A, 1, iWb, 0, 0));
        vecs.push_back(v(1, 'h23, 1, fetchRdy, 0, 1));
        vecs.push_back(v(1, 'h23, 1, decodeV, 0, 1));
        vecs.push_back(v(1, 'h23, 1, memAdr, 0, 1));
        vecs.push_back(v(1, 'h23, 0, memRd, 0, 1));
        vecs.push_back(v(1, 'h23, 0, memRd, 0, 1));
        vecs.push_back(v(1, 'h23, 0, memRd, 0, 1));
        vecs.push_back(v(1, 'h23, 1, memRd, 0, 1));
        vecs.push_back(v(1, 'h23, 1, memWb, 0, 1));
        vecs.push_back(v(1, 'h2B, 1, fetchRdy, 0, 2));
        vecs.push_back(v(1, 'h2B, 1, decodeV, 0, 2));
        vecs.push_back(v(1, 'h2B, 1, memAdr, 0, 2));
        vecs.push_back(v(1, 'h2B, 0, memWr, 0, 2));
        vecs.push_back(v(1, 'h2B, 1, memWr, 0, 2));
        vecs.push_back(v(1, 'h00, 1, fetchRdy, 0, 3));
        vecs.push_back(v(1, 'h00, 1, decodeV, 0, 3));
        vecs.push_back(v(1, 'h00, 1, rtExec, 0, 3));
        vecs.push_back(v(1, 'h00, 1, rtWb, 0, 3));
        vecs.push_back(v(1, 'h08, 1, fetchRdy, 0, 4));
        vecs.push_back(v(1, 'h08, 1, decodeV, 0, 4));
        vecs.push_back(v(1, 'h08, 1, iExecAdd, 0, 4));
        vecs.push_back(v(1, 'h08, 1, iWb, 0, 4));
        vecs.push_back(v(1, 'h04, 1, fetchRdy, 0, 5));
        vecs.push_back(v(1, 'h04, 1, decodeV, 0, 5));
        vecs.push_back(v(1, 'h04, 1, beqV, 0, 5));
        vecs.push_back(v(1, 'h05, 1, fetchRdy, 0, 6));
        vecs.push_back(v(1, 'h05, 1, decodeV, 0, 6));
        vecs.push_back(v(1, 'h05, 1, bneV, 0, 6));
        vecs.push_back(v(1, 'h02, 1, fetchRdy, 0, 7));
        vecs.push_back(v(1, 'h02, 1, decodeV, 0, 7));
        vecs.push_back(v(1, 'h02, 1, jumpV, 0, 7));
        vecs.push_back(v(1, 'h03, 1, fetchRdy, 0, 8));
        vecs.push_back(v(1, 'h03, 1, decodeV, 0, 8));
        vecs.push_back(v(1, 'h03, 1, jalV, 0, 8));
        vecs.push_back(v(1, 'h23, 1, fetchRdy, 0, 9));
        vecs.push_back(v(1, 'h23, 1, decodeV, 0, 9));
        vecs.push_back(v(1, 'h23, 1, memAdr, 0, 9));
        vecs.push_back(v(1, 'h23, 0, memRd, 0, 9));
        vecs.push_back(v(0, 'h23, 0, zeroV, 0, 0));
        vecs.push_back(v(1, 'h23, 0, fetchWait, 0, 0));
        vecs.push_back(v(1, 'h3F, 1, fetchRdy, 0, 0));
        vecs.push_back(v(1, 'h3F, 1, decodeV, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            opCode   = vecs[i].op;
            memReady = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d ctrl", i), 32'(act), 32'(vecs[i].exp));
            check($sformatf("vec%0d illegal", i), 32'(ill), 32'(vecs[i].ill));
            check($sformatf("vec%0d retired", i), ret, vecs[i].ret);
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            opCode   = 6'(i * 3);
            memReady = i[0];
            #1;
            check($sformatf("trap%0d ctrl", i), 32'(act), 32'(zeroV));
            check($sformatf("trap%0d illegal", i), 32'(ill), 32'd1);
            check($sformatf("trap%0d retired", i), ret, 32'd0);
        end

        @(negedge clk);
        reset1 = 1'b1;
        op1    = 6'h3F;
        rdy1   = 1'b0;
        #1;
        check("nohs fetch ctrl", 32'(act1), 32'(fetchRdy));
        check("nohs fetch illegal", 32'(ill1), 32'd0);
        @(negedge clk);
        #1;
        check("pulse decode illegal", 32'(ill1), 32'd1);
        check("pulse decode ctrl", 32'(act1), 32'(decodeV));
        @(negedge clk);
        op1 = 6'h23;
        #1;
        check("pulse cleared", 32'(ill1), 32'd0);
        check("pulse no retire", 32'(ret1), 32'd0);
        check("pulse back to fetch", 32'(act1), 32'(fetchRdy));
        repeat (3) @(negedge clk);
        #1;
        check("nohs memrd ctrl", 32'(act1), 32'(memRd));
        repeat (2) @(negedge clk);
        op1 = 6'h02;
        #1;
        check("nohs lw retired", 32'(ret1), 32'd1);
        check("nohs lw fetch", 32'(act1), 32'(fetchRdy));
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge clk);
            #1;
            check($sformatf("wrap%0d retired", k), 32'(ret1), 32'((k + 2) % 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_v2.md
Name: multicycle_control_v2

Overview:
Next-generation main control FSM for the multicycle MIPS-style CPU. It replaces the fixed single-cycle-memory control unit and drives the same datapath strobes. It adds:
- a memory ready handshake with wait states;
- illegal-opcode detection with a trap mode;
- JAL and BNE sequencing;
- a retired-instruction counter.

It sits between the instruction register opcode field and the datapath muxes and write enables.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored, memory is treated as single-cycle.
- TRAP_ON_ILLEGAL, 1, 1 = an illegal opcode parks the FSM in TRAP; 0 = it returns to FETCH with a one-cycle illegal pulse.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opCode  in  6  IR[31:26].
- mem_ready  in  1  memory read data valid / write accepted.
- PCWriteIfNonZero  out  1  conditional PC write on ALU not-zero.
- PCWriteIfZero  out  1  conditional PC write on ALU zero.
- PCWrite  out  1  unconditional PC write.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemToReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = slt.
- ALUSrcB  out  3  000 = B, 001 = 4, 010 = sext imm, 011 = sext imm<<2, 100 = zext imm.
- ALUSrcA  out  1  0 = PC, 1 = A.
- RegWrite  out  1  register file write.
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31.
- illegal_op  out  1  illegal opcode flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - reset low asynchronously forces state FETCH, retired = 0, illegal_op = 0.
  - All strobe outputs are gated to 0 while reset is low; all mux selects read 0.
  - Reset mid-instruction aborts it with no further writes.
- Opcodes (shared package): RTYPE 00, J 02, JAL 03, BEQ 04, BNE 05, ADDI 08, SLTI 1A, LW 23, SW 2B. Every other value is illegal.
- Only asserted signals are listed per state; every unlisted output is 0.
- FETCH:
  - Asserts MemRead, ALUSrcB = 001, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready = 1 (always when MEM_HANDSHAKE = 0). That cycle goes to DECODE; otherwise stay in FETCH.
- DECODE:
  - Asserts ALUSrcB = 011 (branch target into ALUOut).
  - Next state by opcode:
    - LW/SW -> MEMADR
    - RTYPE -> RTEXEC
    - ADDI/SLTI -> IEXEC
    - BEQ -> BEQ
    - BNE -> BNE
    - J -> JUMP
    - JAL -> JAL
    - illegal -> TRAP, or FETCH when TRAP_ON_ILLEGAL = 0.
- MEMADR: ALUSrcA = 1, ALUSrcB = 010, ALUOp = 00. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead = 1, IorD = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite = 1, RegDst = 00, MemToReg = 01, then FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Holds until mem_ready, then FETCH. MemWrite stays high while holding.
- RTEXEC: ALUSrcA = 1, ALUSrcB = 000, ALUOp = 10, then RTWB.
- RTWB: RegWrite = 1, RegDst = 01, MemToReg = 00, then FETCH.
- IEXEC: ALUSrcA = 1, ALUSrcB = 010, ALUOp = 00 (ADDI) or 11 (SLTI), then IWB.
- IWB: RegWrite = 1, RegDst = 00, MemToReg = 00, then FETCH.
- BEQ / BNE: ALUSrcA = 1, ALUSrcB = 000, ALUOp = 01, PCSource = 01, with PCWriteIfZero (BEQ) or PCWriteIfNonZero (BNE). Then FETCH.
- JUMP: PCWrite = 1, PCSource = 10, then FETCH.
- JAL:
  - Asserts PCWrite = 1, PCSource = 10, RegWrite = 1, RegDst = 10, MemToReg = 10, then FETCH.
  - $31 receives the already-incremented PC.
- TRAP:
  - All strobes are 0 and illegal_op = 1; the FSM stays in TRAP until reset.
  - With TRAP_ON_ILLEGAL = 0, illegal_op is high for exactly the DECODE cycle and retired is not incremented.
- Retired counter:
  - retired increments by 1 on every transition into FETCH from a non-FETCH, non-DECODE state.
  - It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready always 1: LW 5, SW 4, R-type 4, ADDI/SLTI 4, branch 3, J/JAL 3. Each wait cycle adds 1.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode constants;
  - the state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, IEXEC, IWB, BEQ, BNE, JUMP, JAL, TRAP; 4-bit encoding);
  - ALUOp, ALUSrcB, PCSource, MemToReg and RegDst encodings.
- One natural sub-module, ctrl_decode_rom: a purely combinational map from state, opcode and mem_ready to the strobe bundle.
- The top level holds the state register, next-state logic, counter and trap flag.

Test Plan:
- Reset low mid-MEMRD -> all strobes 0 immediately, state FETCH, retired = 0; after release, FETCH asserts MemRead = 1, ALUSrcB = 001.
- opCode = 1A, mem_ready = 1 -> 4-cycle sequence ending in IWB with ALUOp = 11, RegWrite = 1, RegDst = 00; retired = 1.
- opCode = 23, mem_ready low for 3 cycles in MEMRD -> MemRead = 1, IorD = 1 held 4 cycles; MEMWB asserts MemToReg = 01; total 8 cycles; retired = 1.
- opCode = 05 -> BNE state asserts PCWriteIfNonZero = 1, PCWriteIfZero = 0, ALUOp = 01, PCSource = 01; 3 cycles.
- opCode = 03 -> JAL asserts RegDst = 10, MemToReg = 10, PCSource = 10, PCWrite = 1 and RegWrite = 1 in the same cycle.
- opCode = 3F:
  - TRAP_ON_ILLEGAL = 1 -> illegal_op = 1 sticky, no strobes for 20 cycles, retired unchanged.
  - TRAP_ON_ILLEGAL = 0 -> one-cycle illegal_op pulse, then FETCH.
